reg_ctrl_sequencer: RTL and testbench

- Instruction-step control FSM for the register-select/encode datapath.
- Runs fetch, decode and execute steps and drives the per-step datapath strobes: Gra/Grb/Grc, Rin/Rout/BAout, PC/MAR/MDR/IR/Y/Z enables, memory Read/Write and ALU op.
- Handles the memory-ready handshake with a wait timeout, the branch condition, and stop/halt.

---
 rtl/reg_ctrl_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_reg_ctrl_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_ctrl_sequencer.sv
// Instruction-step control FSM for the register-select/encode datapath.
// Drives per-step strobes, memory handshake with timeout, branch and halt.
module reg_ctrl_sequencer #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] IR,
  input  logic        mem_ready,
  input  logic        con_ff,
  input  logic        stop,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        Cout,
  output logic        CONin,
  output logic        Read,
  output logic        Write,
  output logic [3:0]  alu_op,
  output logic        run,
  output logic        illegal_op,
  output logic        mem_err
);

  typedef enum logic [3:0] {
    RST, T0, T1, T2, T3, T4, T5, T6, T7, PAUSE, HALTED
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

  state_t      state, state_n;
  logic [7:0]  wait_cnt;
  logic [4:0]  op;
  logic        unused_ir;
  logic        is_alu, is_addi, is_imm, is_ld, is_st;
  logic        is_br, is_jr, is_nop, is_halt;
  logic        wait_st, timeout;
  logic [3:0]  alu_sel;

  assign op        = IR[31:27];
  assign unused_ir = ^IR[26:0];

  assign is_alu  = op inside {5'b00011, 5'b00100, 5'b00101, 5'b00110};
  assign is_addi = op == 5'b01100;
  assign is_imm  = is_addi || op == 5'b00001;
  assign is_ld   = op == 5'b00000;
  assign is_st   = op == 5'b00010;
  assign is_br   = op == 5'b10010;
  assign is_jr   = op == 5'b10100;
  assign is_nop  = op == 5'b11010;
  assign is_halt = op == 5'b11011;

  always_comb begin
    alu_sel = 4'd0;
    unique case (op)
      5'b00100: alu_sel = 4'd1;
      5'b00101: alu_sel = 4'd2;
      5'b00110: alu_sel = 4'd3;
      default:  alu_sel = 4'd0;
    endcase
  end

  // Memory steps share one wait counter; it only counts while stalled.
  assign wait_st = state == T1
                || (state == T6 && is_ld)
                || (state == T7 && is_st);
  assign timeout = wait_st && !mem_ready && wait_cnt == WAIT_LAST;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= RST;
      wait_cnt <= 8'd0;
      mem_err  <= 1'b0;
    end else begin
      state    <= state_n;
      mem_err  <= mem_err | timeout;
      if (wait_st && !mem_ready && !timeout)
        wait_cnt <= wait_cnt + 8'd1;
      else
        wait_cnt <= 8'd0;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      RST:    state_n = T0;
      T0:     state_n = stop ? PAUSE : T1;
      PAUSE:  state_n = stop ? PAUSE : T0;
      T1: begin
        if (mem_ready)    state_n = T2;
        else if (timeout) state_n = HALTED;
      end
      T2: begin
        if (is_nop)       state_n = T0;
        else if (is_halt) state_n = HALTED;
        else              state_n = T3;
      end
      T3: state_n = (is_alu || is_imm || is_ld || is_st || is_br) ? T4 : T0;
      T4: state_n = T5;
      T5: state_n = (is_ld || is_st || is_br) ? T6 : T0;
      T6: begin
        if (is_st)                     state_n = T7;
        else if (is_ld && mem_ready)   state_n = T7;
        else if (is_ld && timeout)     state_n = HALTED;
        else if (!is_ld)               state_n = T0;
      end
      T7: begin
        if (!is_st || mem_ready) state_n = T0;
        else if (timeout)        state_n = HALTED;
      end
      HALTED: state_n = HALTED;
      default: state_n = RST;
    endcase
  end

  always_comb begin
    {Gra, Grb, Grc, Rin, Rout, BAout} = '0;
    {PCout, PCin, IncPC, MARin, MDRin, MDRout} = '0;
    {IRin, Yin, Zin, Zlowout, Cout, CONin} = '0;
    {Read, Write, illegal_op} = '0;
    alu_op = 4'd0;
    run    = state inside {T0, T1, T2, T3, T4, T5, T6, T7};
    unique case (state)
      T0: begin
        // Gated so a pause does not advance PC before the fetch.
        {PCout, MARin, IncPC, Zin} = {4{!stop}};
      end
      T1: begin
        Read = 1'b1;
        {Zlowout, PCin, MDRin} = {3{mem_ready}};
      end
      T2: {MDRout, IRin} = 2'b11;
      T3: begin
        unique case (1'b1)
          is_alu: {Grb, Rout, Yin} = 3'b111;
          is_imm: begin
            {Grb, Yin} = 2'b11;
            Rout  = is_addi;
            BAout = !is_addi;
          end
          is_ld, is_st: {Grb, BAout, Yin} = 3'b111;
          is_br: {Gra, Rout, CONin} = 3'b111;
          is_jr: {Gra, Rout, PCin} = 3'b111;
          default: illegal_op = 1'b1;
        endcase
      end
      T4: begin
        unique case (1'b1)
          is_alu: begin
            {Grc, Rout, Zin} = 3'b111;
            alu_op = alu_sel;
          end
          is_imm, is_ld, is_st: {Cout, Zin} = 2'b11;
          is_br: {PCout, Yin} = 2'b11;
          default: ;
        endcase
      end
      T5: begin
        unique case (1'b1)
          is_alu, is_imm: {Zlowout, Gra, Rin} = 3'b111;
          is_ld, is_st: {Zlowout, MARin} = 2'b11;
          is_br: {Cout, Zin} = 2'b11;
          default: ;
        endcase
      end
      T6: begin
        unique case (1'b1)
          is_ld: begin
            Read  = 1'b1;
            MDRin = mem_ready;
          end
          is_st: {Gra, Rout, MDRin} = 3'b111;
          is_br: {Zlowout, PCin} = {2{con_ff}};
          default: ;
        endcase
      end
      T7: begin
        unique case (1'b1)
          is_ld: {MDRout, Gra, Rin} = 3'b111;
          is_st: Write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_reg_ctrl_sequencer.sv
// Scoreboard bench for reg_ctrl_sequencer: driver queues expected outputs,
// a negedge monitor pops and compares them cycle by cycle.
module tb_reg_ctrl_sequencer;

  logic        clock, reset;
  logic [31:0] IR;
  logic        mem_ready, con_ff, stop;
  logic Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC, MARin;
  logic MDRin, MDRout, IRin, Yin, Zin, Zlowout, Cout, CONin, Read, Write;
  logic [3:0]  alu_op;
  logic        run, illegal_op, mem_err;
  logic [26:0] outs;

  reg_ctrl_sequencer #(.MEM_WAIT_MAX(15)) dut (
    .clock(clock), .reset(reset), .IR(IR), .mem_ready(mem_ready),
    .con_ff(con_ff), .stop(stop),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .BAout(BAout), .PCout(PCout), .PCin(PCin), .IncPC(IncPC),
    .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
    .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .Cout(Cout),
    .CONin(CONin), .Read(Read), .Write(Write), .alu_op(alu_op),
    .run(run), .illegal_op(illegal_op), .mem_err(mem_err)
  );

  assign outs = {mem_err, illegal_op, run, alu_op, Write, Read, CONin,
                 Cout, Zlowout, Zin, Yin, IRin, MDRout, MDRin, MARin,
                 IncPC, PCin, PCout, BAout, Rout, Rin, Grc, Grb, Gra};

  localparam logic [26:0] GRA = 27'd1 << 0, GRB = 27'd1 << 1;
  localparam logic [26:0] GRC = 27'd1 << 2, RIN = 27'd1 << 3;
  localparam logic [26:0] ROUT = 27'd1 << 4, BAOUT = 27'd1 << 5;
  localparam logic [26:0] PCOUT = 27'd1 << 6, PCIN = 27'd1 << 7;
  localparam logic [26:0] INCPC = 27'd1 << 8, MARIN = 27'd1 << 9;
  localparam logic [26:0] MDRIN = 27'd1 << 10, MDROUT = 27'd1 << 11;
  localparam logic [26:0] IRIN = 27'd1 << 12, YIN = 27'd1 << 13;
  localparam logic [26:0] ZIN = 27'd1 << 14, ZLOW = 27'd1 << 15;
  localparam logic [26:0] COUT = 27'd1 << 16, CONIN = 27'd1 << 17;
  localparam logic [26:0] READ = 27'd1 << 18, WRITE = 27'd1 << 19;
  localparam logic [26:0] ALU1 = 27'd1 << 20, ALU3 = 27'd3 << 20;
  localparam logic [26:0] RUN = 27'd1 << 24, ILL = 27'd1 << 25;
  localparam logic [26:0] MERR = 27'd1 << 26;

  localparam logic [26:0] F0 = PCOUT | MARIN | INCPC | ZIN | RUN;
  localparam logic [26:0] F1 = READ | ZLOW | PCIN | MDRIN | RUN;
  localparam logic [26:0] F2 = MDROUT | IRIN | RUN;

  localparam logic [4:0] OP_LD = 5'b00000, OP_LDI = 5'b00001;
  localparam logic [4:0] OP_ST = 5'b00010, OP_ADD = 5'b00011;
  localparam logic [4:0] OP_SUB = 5'b00100, OP_OR = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100, OP_BR = 5'b10010;
  localparam logic [4:0] OP_JR = 5'b10100, OP_NOP = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011, OP_BAD = 5'b11111;

  typedef struct {
    int          cyc;
    logic [26:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;

  logic [4:0] cur_op;
  logic       cur_cf, cur_stop, cur_rn;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (e.cyc != cyc)
          $display("FAIL %s: stale entry cyc %0d at cyc %0d",
                   e.name, e.cyc, cyc);
        else if (outs !== e.exp)
          $display("FAIL %s: cyc %0d got %h expected %h",
                   e.name, cyc, outs, e.exp);
        else
          passed++;
      end
    end
  end

  task automatic step(input logic mr, input logic [26:0] e,
                      input string nm);
    IR        = {cur_op, 27'h2A5A5A5};
    mem_ready = mr;
    con_ff    = cur_cf;
    stop      = cur_stop;
    reset     = cur_rn;
    sb.push_back('{cyc, e, nm});
    @(posedge clock);
    #1;
  endtask

  task automatic fetch(input logic [4:0] op);
    cur_op = op;
    step(1'b0, F0, "t0");
    step(1'b1, F1, "t1");
    step(1'b0, F2, "t2");
  endtask

  initial begin
    cur_op = OP_NOP; cur_cf = 0; cur_stop = 0; cur_rn = 0;
    reset = 0; IR = '0; mem_ready = 0; con_ff = 0; stop = 0;
    @(posedge clock); #1;
    step(1'b0, '0, "rst0");
    step(1'b1, '0, "rst1");
    cur_rn = 1;
    step(1'b0, '0, "rst_rel");

    fetch(OP_ADD);
    step(1'b1, GRB | ROUT | YIN | RUN, "add_t3");
    step(1'b1, GRC | ROUT | ZIN | RUN, "add_t4");
    step(1'b1, ZLOW | GRA | RIN | RUN, "add_t5");
    fetch(OP_SUB);
    step(1'b0, GRB | ROUT | YIN | RUN, "sub_t3");
    step(1'b0, GRC | ROUT | ZIN | ALU1 | RUN, "sub_t4");
    step(1'b0, ZLOW | GRA | RIN | RUN, "sub_t5");
    fetch(OP_OR);
    step(1'b0, GRB | ROUT | YIN | RUN, "or_t3");
    step(1'b0, GRC | ROUT | ZIN | ALU3 | RUN, "or_t4");
    step(1'b0, ZLOW | GRA | RIN | RUN, "or_t5");
    fetch(OP_ADDI);
    step(1'b0, GRB | ROUT | YIN | RUN, "addi_t3");
    step(1'b0, COUT | ZIN | RUN, "addi_t4");
    step(1'b0, ZLOW | GRA | RIN | RUN, "addi_t5");
    fetch(OP_LDI);
    step(1'b0, GRB | BAOUT | YIN | RUN, "ldi_t3");
    step(1'b0, COUT | ZIN | RUN, "ldi_t4");
    step(1'b0, ZLOW | GRA | RIN | RUN, "ldi_t5");

    fetch(OP_LD);
    step(1'b0, GRB | BAOUT | YIN | RUN, "ld_t3");
    step(1'b0, COUT | ZIN | RUN, "ld_t4");
    step(1'b0, ZLOW | MARIN | RUN, "ld_t5");
    repeat (3) step(1'b0, READ | RUN, "ld_t6_wait");
    step(1'b1, READ | MDRIN | RUN, "ld_t6_rdy");
    step(1'b0, MDROUT | GRA | RIN | RUN, "ld_t7");

    for (int k = 0; k < 2; k++) begin
      fetch(OP_BR);
      step(1'b0, GRA | ROUT | CONIN | RUN, "br_t3");
      step(1'b0, PCOUT | YIN | RUN, "br_t4");
      step(1'b0, COUT | ZIN | RUN, "br_t5");
      cur_cf = (k == 1);
      step(1'b0, (k == 1) ? (ZLOW | PCIN | RUN) : RUN, "br_t6");
      cur_cf = 0;
    end

    fetch(OP_JR);
    step(1'b0, GRA | ROUT | PCIN | RUN, "jr_t3");
    fetch(OP_NOP);
    fetch(OP_BAD);
    step(1'b0, ILL | RUN, "bad_t3");

    fetch(OP_ST);
    step(1'b0, GRB | BAOUT | YIN | RUN, "st_t3");
    cur_stop = 1;
    step(1'b0, COUT | ZIN | RUN, "st_t4");
    step(1'b0, ZLOW | MARIN | RUN, "st_t5");
    step(1'b0, GRA | ROUT | MDRIN | RUN, "st_t6");
    step(1'b0, WRITE | RUN, "st_t7_wait");
    step(1'b1, WRITE | RUN, "st_t7_rdy");
    step(1'b0, RUN, "stop_t0");
    repeat (2) step(1'b0, '0, "pause");
    cur_stop = 0;
    step(1'b0, '0, "pause_exit");

    fetch(OP_HALT);
    repeat (20) step(1'b1, '0, "halted");
    cur_rn = 0;
    step(1'b0, '0, "rst_halt");
    cur_rn = 1;
    step(1'b0, '0, "rel_halt");

    cur_op = OP_ADD;
    step(1'b0, F0, "to_t0");
    repeat (15) step(1'b0, READ | RUN, "to_wait");
    repeat (3) step(1'b0, MERR, "to_halted");
    step(1'b1, MERR, "to_late_rdy");
    cur_rn = 0;
    step(1'b0, '0, "rst_to");
    cur_rn = 1;
    step(1'b0, '0, "rel_to");

    fetch(OP_LD);
    step(1'b0, GRB | BAOUT | YIN | RUN, "ld2_t3");
    step(1'b0, COUT | ZIN | RUN, "ld2_t4");
    step(1'b0, ZLOW | MARIN | RUN, "ld2_t5");
    step(1'b0, READ | RUN, "ld2_t6");
    cur_rn = 0;
    step(1'b0, '0, "async_rst");
    step(1'b1, '0, "async_hold");
    cur_rn = 1;
    step(1'b0, '0, "rel_async");
    fetch(OP_NOP);
    step(1'b0, F0, "final_t0");

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clock);
    if (sb.size() > 0) begin
      $display("FAIL drain: %0d expectations left unchecked", sb.size());
      checks += sb.size();
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
